// File: rtl/sys_pkg.sv
// Shared types and default constants for the step-clock controller.
// Holds the FSM state encoding and default timing values.
// Also provides a counter-width helper that never returns zero.
package sys_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } step_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;   // 10 ms at 50 MHz
    localparam int DEF_HALF_PERIOD     = 25000000; // 0.5 s high, 0.5 s low
    localparam int DEF_BURST_LEN       = 4;
    localparam int DEF_CNT_W           = 16;

    // Width of a counter that must hold 0..n-1; at least one bit so n=1 stays legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_debounce.sv
// Purpose: 2-flop synchroniser plus stability-counter debounce for one raw input.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles before the level changes.
// Backpressure: none; press_o is a single-cycle pulse on an accepted 0->1 change.
module sys_debounce
    import sys_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            btn_db_q, btn_db_d;
    logic            press_q, press_d;

    // Next-state: count consecutive cycles the synced input disagrees with the accepted level.
    always_comb begin
        sync1_d  = raw_i;
        sync2_d  = sync1_q;
        db_cnt_d = db_cnt_q;
        btn_db_d = btn_db_q;
        press_d  = 1'b0;
        if (sync2_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_db_d = sync2_q;
            db_cnt_d = '0;
            press_d  = sync2_q;   // only a rising acceptance is a press
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // State registers; everything clears on reset so no spurious press follows release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_cnt_q <= '0;
            btn_db_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_cnt_q <= db_cnt_d;
            btn_db_q <= btn_db_d;
            press_q  <= press_d;
        end
    end

    assign level_o = btn_db_q;
    assign press_o = press_q;

endmodule

// File: rtl/sys_step_clk_ctrl.sv
// Purpose: CPU clock generator, free-run or single-step (STEP_BURST_EN: burst of BURST_LEN periods per press).
// Latency: press pulse in cycle n -> SYS_clk high from cycle n+1; sw_run adds 2 sync cycles.
// Backpressure: presses arriving while a period/burst is in progress are dropped, never queued.
module sys_step_clk_ctrl
    import sys_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HALF_PERIOD     = DEF_HALF_PERIOD,
    parameter int BURST_LEN       = DEF_BURST_LEN,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             SYS_clk_50,
    input  logic             SYS_reset_n,
    input  logic             btn_step,
    input  logic             sw_run,
    output logic             SYS_clk,
    output logic             busy,
    output logic [CNT_W-1:0] step_count
);

    localparam int              PH_W    = cnt_width(HALF_PERIOD);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

    logic press;
    logic btn_level_unused;

    sys_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk     (SYS_clk_50),
        .rst_n   (SYS_reset_n),
        .raw_i   (btn_step),
        .level_o (btn_level_unused),
        .press_o (press)
    );

    logic             run_s1_q, run_s1_d;
    logic             run_s_q, run_s_d;
    step_state_t      state_q, state_d;
    logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
    logic             sys_clk_q, sys_clk_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             burst_pend;

`ifdef STEP_BURST_EN
    localparam int               REM_W    = cnt_width(BURST_LEN);
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(BURST_LEN - 1);

    logic [REM_W-1:0] rem_q, rem_d;

    assign burst_pend = (rem_q != '0);
`else
    logic [31:0] unused_burst_len;

    assign unused_burst_len = BURST_LEN;
    assign burst_pend       = 1'b0;
`endif

    // Next-state for the mode synchroniser, phase FSM and registered outputs.
    always_comb begin
        run_s1_d   = sw_run;
        run_s_d    = run_s1_q;
        state_d    = state_q;
        ph_cnt_d   = ph_cnt_q;
        step_cnt_d = step_cnt_q;
`ifdef STEP_BURST_EN
        rem_d      = rem_q;
`endif
        case (state_q)
            IDLE: begin
                ph_cnt_d = '0;
                // run wins over a simultaneous press, so only one period starts
                if (run_s_q || press) begin
                    state_d    = HIGH;
                    step_cnt_d = step_cnt_q + CNT_W'(1);
`ifdef STEP_BURST_EN
                    // a free-run start carries no burst; the press path loads the remainder
                    rem_d      = run_s_q ? '0 : REM_LOAD;
`endif
                end
            end
            HIGH: begin
                if (ph_cnt_q == PH_LAST) begin
                    state_d  = LOW;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            LOW: begin
                if (ph_cnt_q == PH_LAST) begin
                    ph_cnt_d = '0;
                    if (run_s_q || burst_pend) begin
                        state_d    = HIGH;
                        step_cnt_d = step_cnt_q + CNT_W'(1);
`ifdef STEP_BURST_EN
                        if (burst_pend) begin
                            rem_d = rem_q - REM_W'(1);
                        end
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                ph_cnt_d = '0;
            end
        endcase
        // outputs are registered copies of the next state, so SYS_clk cannot glitch
        sys_clk_d = (state_d == HIGH);
        busy_d    = (state_d != IDLE);
    end

    // All controller state; reset drops SYS_clk immediately and leaves nothing pending.
    always_ff @(posedge SYS_clk_50 or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            run_s1_q   <= 1'b0;
            run_s_q    <= 1'b0;
            state_q    <= IDLE;
            ph_cnt_q   <= '0;
            sys_clk_q  <= 1'b0;
            busy_q     <= 1'b0;
            step_cnt_q <= '0;
`ifdef STEP_BURST_EN
            rem_q      <= '0;
`endif
        end else begin
            run_s1_q   <= run_s1_d;
            run_s_q    <= run_s_d;
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            sys_clk_q  <= sys_clk_d;
            busy_q     <= busy_d;
            step_cnt_q <= step_cnt_d;
`ifdef STEP_BURST_EN
            rem_q      <= rem_d;
`endif
        end
    end

    assign SYS_clk    = sys_clk_q;
    assign busy       = busy_q;
    assign step_count = step_cnt_q;

endmodule

// File: tb/tb_sys_step_clk_ctrl.sv
// Directed bench for sys_step_clk_ctrl: segment tables of {inputs, expected outputs}.
// Small timing parameters; a second instance covers the HALF_PERIOD=1 case.
// Each table row holds the inputs for n cycles and the outputs expected in every one of them.
module tb_sys_step_clk_ctrl;

    localparam int CW = 4;
`ifdef STEP_BURST_EN
    localparam int NB = 4;
`else
    localparam int NB = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          btn_step;
    logic          sw_run;
    logic          sys_clk_o, busy_o;
    logic [CW-1:0] cnt_o;
    logic          h1_clk_o, h1_busy_o;
    logic [CW-1:0] h1_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit    btn;
        bit    run;
        int    n;
        bit    e_clk;
        bit    e_busy;
        int    e_cnt;
        string tag;
    } vec_t;

    vec_t tbl[$];

    sys_step_clk_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .HALF_PERIOD     (3),
        .BURST_LEN       (4),
        .CNT_W           (CW)
    ) u_dut (
        .SYS_clk_50  (clk),
        .SYS_reset_n (rst_n),
        .btn_step    (btn_step),
        .sw_run      (sw_run),
        .SYS_clk     (sys_clk_o),
        .busy        (busy_o),
        .step_count  (cnt_o)
    );

    sys_step_clk_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .HALF_PERIOD     (1),
        .BURST_LEN       (4),
        .CNT_W           (CW)
    ) u_dut_h1 (
        .SYS_clk_50  (clk),
        .SYS_reset_n (rst_n),
        .btn_step    (btn_step),
        .sw_run      (sw_run),
        .SYS_clk     (h1_clk_o),
        .busy        (h1_busy_o),
        .step_count  (h1_cnt_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit b, input bit r, input int n, input bit c, input bit bz,
                       input int k, input string tag);
        vec_t v;
        v.btn = b; v.run = r; v.n = n; v.e_clk = c; v.e_busy = bz; v.e_cnt = k; v.tag = tag;
        tbl.push_back(v);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic run_table();
        foreach (tbl[i]) begin
            btn_step = tbl[i].btn;
            sw_run   = tbl[i].run;
            for (int k = 0; k < tbl[i].n; k++) begin
                @(negedge clk);
                check({tbl[i].tag, "_clk"},  sys_clk_o, tbl[i].e_clk);
                check({tbl[i].tag, "_busy"}, busy_o,    tbl[i].e_busy);
                check({tbl[i].tag, "_cnt"},  cnt_o,     tbl[i].e_cnt);
                @(posedge clk);
                #1;
            end
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        btn_step = 1'b0;
        sw_run   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_clk",    sys_clk_o, 0);
        check("rst_busy",   busy_o,    0);
        check("rst_cnt",    cnt_o,     0);
        check("rst_h1_clk", h1_clk_o,  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_step = 1'b0;
        sw_run   = 1'b0;

        // Single press held 20 cycles: press pulse after 6 edges, SYS_clk from the 7th.
        do_reset();
        add(1, 0, 7, 0, 0, 0, "press_wait");
        for (int p = 1; p <= NB; p++) begin
            add(1, 0, 3, 1, 1, p, "press_hi");
            add(1, 0, 3, 0, 1, p, "press_lo");
        end
        add(1, 0, 6, 0, 0, NB, "press_idle");
        add(0, 0, 10, 0, 0, NB, "release");
        run_table();

        // 2-cycle bounces never stay stable for 4 cycles: no press.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            add(1, 0, 2, 0, 0, 0, "bounce_1");
            add(0, 0, 2, 0, 0, 0, "bounce_0");
        end
        add(0, 0, 12, 0, 0, 0, "bounce_quiet");
        run_table();

        // Free-run: 10 rising edges, sw_run drops mid-HIGH, current period finishes.
        do_reset();
        add(0, 1, 3, 0, 0, 0, "run_sync");
        for (int p = 1; p <= 9; p++) begin
            add(0, 1, 3, 1, 1, p, "run_hi");
            add(0, 1, 3, 0, 1, p, "run_lo");
        end
        add(0, 1, 1, 1, 1, 10, "run_last_hi");
        add(0, 0, 2, 1, 1, 10, "run_drop_hi");
        add(0, 0, 3, 0, 1, 10, "run_drop_lo");
        add(0, 0, 6, 0, 0, 10, "run_idle");
        run_table();

        // Press lands during LOW of a free-run period: dropped, exactly one period.
        do_reset();
        add(1, 1, 3, 0, 0, 0, "busy_sync");
        add(1, 1, 1, 1, 1, 1, "busy_hi0");
        add(1, 0, 2, 1, 1, 1, "busy_hi1");
        add(1, 0, 3, 0, 1, 1, "busy_lo");
        add(1, 0, 6, 0, 0, 1, "busy_idle");
        run_table();

        // press and run_s coincide in IDLE: a single period start.
        do_reset();
        add(1, 0, 4, 0, 0, 0, "both_wait");
        add(1, 1, 1, 0, 0, 0, "both_run");
        add(1, 0, 2, 0, 0, 0, "both_wait2");
        add(1, 0, 3, 1, 1, 1, "both_hi");
        add(1, 0, 3, 0, 1, 1, "both_lo");
        add(1, 0, 6, 0, 0, 1, "both_idle");
        run_table();

        // Long free-run: step_count wraps at 2^CW; HALF_PERIOD=1 instance toggles every cycle.
        do_reset();
        sw_run = 1'b1;
        for (int c = 0; c < 110; c++) begin
            int  e_cnt, e_h1cnt;
            bit  e_clk, e_h1clk;
            e_clk   = (c >= 3) && (((c - 3) % 6) < 3);
            e_cnt   = (c >= 3) ? (((c - 3) / 6 + 1) % 16) : 0;
            e_h1clk = (c >= 3) && (((c - 3) % 2) == 0);
            e_h1cnt = (c >= 3) ? (((c - 3) / 2 + 1) % 16) : 0;
            @(negedge clk);
            check("wrap_clk",  sys_clk_o, e_clk);
            check("wrap_cnt",  cnt_o,     e_cnt);
            check("h1_clk",    h1_clk_o,  e_h1clk);
            check("h1_cnt",    h1_cnt_o,  e_h1cnt);
            check("h1_busy",   h1_busy_o, (c >= 3));
            if (c == 93) check("wrap_zero", cnt_o, 0);
            @(posedge clk);
            #1;
        end

        // Reset asserted while SYS_clk is high: output drops at once, no pulse after release.
        do_reset();
        sw_run = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (sys_clk_o === 1'b1) seen = 1'b1;
            end
            check("midrst_seen_high", seen, 1);
        end
        #2;
        rst_n  = 1'b0;
        sw_run = 1'b0;
        #1;
        check("midrst_clk",  sys_clk_o, 0);
        check("midrst_cnt",  cnt_o,     0);
        check("midrst_busy", busy_o,    0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        add(0, 0, 12, 0, 0, 0, "post_rst");
        run_table();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
